// File: rtl/controlador_transaccion_pkg.sv
// rtl/controlador_transaccion_pkg.sv - shared types and constants for the transaction-layer controller
// Contents: state encodings, FIFO bit indices for the 5-bit status vectors,
// threshold width and the next-state function used by the controller FSM.
package controlador_transaccion_pkg;

  localparam int UMBRAL_W  = 4;
  localparam int NUM_FIFOS = 5;

  // Bit positions inside fifo_empty / fifo_error / error_full
  localparam int IDX_MF  = 0;
  localparam int IDX_VC0 = 1;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 3;
  localparam int IDX_D1  = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Next state when reset is low. Priority inside each state: error > init > emptiness.
  function automatic state_t fsm_next(state_t cur, logic init, logic any_err, logic all_empty);
    state_t nxt;
    case (cur)
      ST_RESET:  nxt = ST_INIT;
      ST_INIT:   nxt = any_err ? ST_ERROR : (init ? ST_INIT : ST_IDLE);
      ST_IDLE:   nxt = any_err ? ST_ERROR : (init ? ST_INIT : (all_empty ? ST_IDLE : ST_ACTIVE));
      ST_ACTIVE: nxt = any_err ? ST_ERROR : (init ? ST_INIT : (all_empty ? ST_IDLE : ST_ACTIVE));
      ST_ERROR:  nxt = ST_ERROR;
      default:   nxt = ST_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/controlador_transaccion_if.sv
// rtl/controlador_transaccion_if.sv - FIFO status/control bus between the controller and the FIFOs
// Signals: occupancy counts, empty and error flags (FIFO -> controller);
// thresholds and pause signals (controller -> FIFOs/producers).
// Modports: master = controller side, slave = FIFO/datapath side.
interface controlador_transaccion_if
  import controlador_transaccion_pkg::*;
#(
  parameter int CNT_W = 5
) ();

  logic [CNT_W-1:0]     mf_count;
  logic [CNT_W-1:0]     vc0_count;
  logic [CNT_W-1:0]     vc1_count;
  logic [CNT_W-1:0]     d0_count;
  logic [CNT_W-1:0]     d1_count;
  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [NUM_FIFOS-1:0] fifo_error;

  logic [UMBRAL_W-1:0]  Umbral_MF;
  logic [UMBRAL_W-1:0]  Umbral_VC;
  logic [UMBRAL_W-1:0]  Umbral_D;
  logic                 Main_pause;
  logic                 VC0_pause;
  logic                 VC1_pause;
  logic                 D_pause;

  modport master (
    input  mf_count, vc0_count, vc1_count, d0_count, d1_count,
    input  fifo_empty, fifo_error,
    output Umbral_MF, Umbral_VC, Umbral_D,
    output Main_pause, VC0_pause, VC1_pause, D_pause
  );

  modport slave (
    output mf_count, vc0_count, vc1_count, d0_count, d1_count,
    output fifo_empty, fifo_error,
    input  Umbral_MF, Umbral_VC, Umbral_D,
    input  Main_pause, VC0_pause, VC1_pause, D_pause
  );

endinterface

// File: rtl/controlador_transaccion_umbral_cmp.sv
// rtl/controlador_transaccion_umbral_cmp.sv - almost-full comparator for one FIFO
// Ports: count (occupancy), umbral (threshold) in; almost_full out,
// asserted when count + umbral >= DEPTH.
module umbral_cmp
  import controlador_transaccion_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0]    count,
  input  logic [UMBRAL_W-1:0] umbral,
  output logic                almost_full
);

  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  // One extra bit so count + umbral can never wrap back below DEPTH
  logic [CNT_W:0] sum;

  assign sum         = {1'b0, count} + (CNT_W+1)'(umbral);
  assign almost_full = (sum >= DEPTH_V);

endmodule

// File: rtl/controlador_transaccion.sv
// rtl/controlador_transaccion.sv - transaction-layer control FSM, threshold registers and pause generation
// Ports: clk, reset (sync, active-high), init, Umbral_*_in thresholds to capture;
// fifo_bus (master modport) carries counts/empty/error in and Umbral_*/pauses out;
// state, idle_out, active_out, error_out, error_full status outputs.
module controlador_transaccion
  import controlador_transaccion_pkg::*;
#(
  parameter int MF_DEPTH = 8,
  parameter int VC_DEPTH = 16,
  parameter int D_DEPTH  = 4,
  parameter int CNT_W    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [UMBRAL_W-1:0]       Umbral_MF_in,
  input  logic [UMBRAL_W-1:0]       Umbral_VC_in,
  input  logic [UMBRAL_W-1:0]       Umbral_D_in,
  controlador_transaccion_if.master fifo_bus,
  output logic [2:0]                state,
  output logic                      idle_out,
  output logic                      active_out,
  output logic                      error_out,
  output logic [NUM_FIFOS-1:0]      error_full
);

  state_t              state_q;
  state_t              state_nxt;
  logic [UMBRAL_W-1:0] umbral_mf_q;
  logic [UMBRAL_W-1:0] umbral_vc_q;
  logic [UMBRAL_W-1:0] umbral_d_q;
  logic                any_err;
  logic                all_empty;

  assign any_err   = |fifo_bus.fifo_error;
  assign all_empty = &fifo_bus.fifo_empty;
  assign state_nxt = fsm_next(state_q, init, any_err, all_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      umbral_mf_q <= '0;
      umbral_vc_q <= '0;
      umbral_d_q  <= '0;
      error_full  <= '0;
      idle_out    <= 1'b0;
      active_out  <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      idle_out   <= (state_nxt == ST_IDLE);
      active_out <= (state_nxt == ST_ACTIVE);
      error_out  <= (state_nxt == ST_ERROR);

      // Capture on every INIT clock, even the one that exits to ERROR
      if (state_q == ST_INIT) begin
        umbral_mf_q <= Umbral_MF_in;
        umbral_vc_q <= Umbral_VC_in;
        umbral_d_q  <= Umbral_D_in;
      end

      // Errors are recorded in every state except RESET; ERROR keeps accumulating
      if (state_q inside {ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR}) begin
        error_full <= error_full | fifo_bus.fifo_error;
      end
    end
  end

  assign state              = state_q;
  assign fifo_bus.Umbral_MF = umbral_mf_q;
  assign fifo_bus.Umbral_VC = umbral_vc_q;
  assign fifo_bus.Umbral_D  = umbral_d_q;

  logic af_mf, af_vc0, af_vc1, af_d0, af_d1;

  umbral_cmp #(.DEPTH(MF_DEPTH), .CNT_W(CNT_W)) u_cmp_mf (
    .count(fifo_bus.mf_count),  .umbral(umbral_mf_q), .almost_full(af_mf)
  );
  umbral_cmp #(.DEPTH(VC_DEPTH), .CNT_W(CNT_W)) u_cmp_vc0 (
    .count(fifo_bus.vc0_count), .umbral(umbral_vc_q), .almost_full(af_vc0)
  );
  umbral_cmp #(.DEPTH(VC_DEPTH), .CNT_W(CNT_W)) u_cmp_vc1 (
    .count(fifo_bus.vc1_count), .umbral(umbral_vc_q), .almost_full(af_vc1)
  );
  umbral_cmp #(.DEPTH(D_DEPTH), .CNT_W(CNT_W)) u_cmp_d0 (
    .count(fifo_bus.d0_count),  .umbral(umbral_d_q),  .almost_full(af_d0)
  );
  umbral_cmp #(.DEPTH(D_DEPTH), .CNT_W(CNT_W)) u_cmp_d1 (
    .count(fifo_bus.d1_count),  .umbral(umbral_d_q),  .almost_full(af_d1)
  );

  // Pauses stay combinational so a producer sees them in the cycle it pushes
  logic main_pause, vc0_pause, vc1_pause, d_pause;

  always_comb begin
    main_pause = 1'b0;
    vc0_pause  = 1'b0;
    vc1_pause  = 1'b0;
    d_pause    = 1'b0;
    case (state_q)
      ST_ERROR: begin
        main_pause = 1'b1;
        vc0_pause  = 1'b1;
        vc1_pause  = 1'b1;
        d_pause    = 1'b1;
      end
      ST_INIT, ST_IDLE, ST_ACTIVE: begin
        main_pause = af_mf;
        vc0_pause  = af_vc0;
        vc1_pause  = af_vc1;
        d_pause    = af_d0 | af_d1;
      end
      default: ;
    endcase
  end

  assign fifo_bus.Main_pause = main_pause;
  assign fifo_bus.VC0_pause  = vc0_pause;
  assign fifo_bus.VC1_pause  = vc1_pause;
  assign fifo_bus.D_pause    = d_pause;

endmodule

// File: tb/tb_controlador_transaccion.sv
// tb/tb_controlador_transaccion.sv - self-checking bench for controlador_transaccion
module tb_controlador_transaccion;

  localparam int MF_DEPTH = 8;
  localparam int VC_DEPTH = 16;
  localparam int D_DEPTH  = 4;
  localparam int CNT_W    = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umf_in, uvc_in, ud_in;
  logic [2:0] state;
  logic       idle_out, active_out, error_out;
  logic [4:0] error_full;

  controlador_transaccion_if #(.CNT_W(CNT_W)) bus ();

  controlador_transaccion #(
    .MF_DEPTH(MF_DEPTH), .VC_DEPTH(VC_DEPTH), .D_DEPTH(D_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .Umbral_MF_in(umf_in),
    .Umbral_VC_in(uvc_in),
    .Umbral_D_in(ud_in),
    .fifo_bus(bus),
    .state(state),
    .idle_out(idle_out),
    .active_out(active_out),
    .error_out(error_out),
    .error_full(error_full)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: states 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
  int         m_state = 0;
  int         m_umf = 0, m_uvc = 0, m_ud = 0;
  logic [4:0] m_ef = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic bit over(int count, int umbral, int depth);
    return (count + umbral) >= depth;
  endfunction

  // Advance the model with the inputs the DUT is about to sample
  task automatic model_step();
    bit any_err   = (bus.fifo_error != 5'd0);
    bit all_empty = (bus.fifo_empty == 5'h1f);
    if (reset) begin
      m_state = 0; m_umf = 0; m_uvc = 0; m_ud = 0; m_ef = '0;
    end else begin
      if (m_state != 0) m_ef = m_ef | bus.fifo_error;
      if (m_state == 1) begin
        m_umf = umf_in; m_uvc = uvc_in; m_ud = ud_in;
      end
      if (m_state == 0)       m_state = 1;
      else if (m_state == 4)  m_state = 4;
      else if (any_err)       m_state = 4;
      else if (init)          m_state = 1;
      else if (m_state == 1)  m_state = 2;
      else                    m_state = all_empty ? 2 : 3;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    bit pm, p0, p1, pd;
    if (m_state == 0) begin
      pm = 0; p0 = 0; p1 = 0; pd = 0;
    end else if (m_state == 4) begin
      pm = 1; p0 = 1; p1 = 1; pd = 1;
    end else begin
      pm = over(int'(bus.mf_count), m_umf, MF_DEPTH);
      p0 = over(int'(bus.vc0_count), m_uvc, VC_DEPTH);
      p1 = over(int'(bus.vc1_count), m_uvc, VC_DEPTH);
      pd = over(int'(bus.d0_count), m_ud, D_DEPTH) || over(int'(bus.d1_count), m_ud, D_DEPTH);
    end
    chk($sformatf("%s.state", tag), state, m_state);
    chk($sformatf("%s.flags", tag), {idle_out, active_out, error_out},
        {m_state == 2, m_state == 3, m_state == 4});
    chk($sformatf("%s.umbral", tag), {bus.Umbral_MF, bus.Umbral_VC, bus.Umbral_D},
        {m_umf[3:0], m_uvc[3:0], m_ud[3:0]});
    chk($sformatf("%s.error_full", tag), error_full, m_ef);
    chk($sformatf("%s.pauses", tag), {bus.Main_pause, bus.VC0_pause, bus.VC1_pause, bus.D_pause},
        {pm, p0, p1, pd});
  endtask

  initial begin
    reset = 1'b1; init = 1'b0;
    umf_in = '0; uvc_in = '0; ud_in = '0;
    bus.mf_count = '0; bus.vc0_count = '0; bus.vc1_count = '0;
    bus.d0_count = '0; bus.d1_count = '0;
    bus.fifo_empty = 5'h1f; bus.fifo_error = '0;

    // Reset then init
    tick(); tick();
    check_all("reset");
    chk("reset_state", state, 3'd0);
    reset = 1'b0;
    tick();
    chk("leave_reset", state, 3'd1);
    init = 1'b1; umf_in = 4'd1; uvc_in = 4'd3; ud_in = 4'd1;
    tick();
    init = 1'b0;
    tick();
    check_all("init_done");
    chk("init_umbral", {bus.Umbral_MF, bus.Umbral_VC, bus.Umbral_D}, {4'd1, 4'd3, 4'd1});
    chk("init_idle", state, 3'd2);

    // Traffic
    bus.fifo_empty = 5'h1e;
    tick();
    chk("to_active", state, 3'd3);
    bus.fifo_empty = 5'h1f;
    tick();
    chk("to_idle", state, 3'd2);

    // Thresholds: MF=1, VC=0, D=4
    init = 1'b1; umf_in = 4'd1; uvc_in = 4'd0; ud_in = 4'd4;
    tick();
    init = 1'b0;
    tick();
    check_all("thr_load");
    bus.mf_count = 5'd6; #1;
    chk("mf6_pause", bus.Main_pause, 1'b0);
    bus.mf_count = 5'd7; #1;
    chk("mf7_pause", bus.Main_pause, 1'b1);
    bus.vc0_count = 5'd15; #1;
    chk("vc15_pause", bus.VC0_pause, 1'b0);
    bus.vc0_count = 5'd16; #1;
    chk("vc16_pause", bus.VC0_pause, 1'b1);
    bus.d1_count = 5'd0; #1;
    chk("d_um4_pause", bus.D_pause, 1'b1);
    check_all("thr_all");
    bus.mf_count = '0; bus.vc0_count = '0;

    // Error
    bus.fifo_empty = 5'h1e;
    tick();
    chk("err_pre_active", state, 3'd3);
    bus.fifo_error = 5'b01000;
    tick();
    bus.fifo_error = '0; #1;
    check_all("err");
    chk("err_state", state, 3'd4);
    chk("err_full", error_full, 5'b01000);
    chk("err_pauses", {bus.Main_pause, bus.VC0_pause, bus.VC1_pause, bus.D_pause}, 4'hf);
    init = 1'b1;
    tick();
    chk("err_ignores_init", state, 3'd4);
    init = 1'b0;
    reset = 1'b1;
    tick();
    check_all("err_reset");
    chk("err_reset_ef", error_full, 5'd0);
    chk("err_reset_pause", bus.Main_pause, 1'b0);
    reset = 1'b0;

    // Re-init mid-traffic
    tick();
    tick();
    tick();
    chk("reinit_active", state, 3'd3);
    init = 1'b1; umf_in = 4'd2; uvc_in = 4'd2; ud_in = 4'd2;
    tick();
    chk("reinit_state", state, 3'd1);
    tick();
    chk("reinit_umbral", {bus.Umbral_MF, bus.Umbral_VC, bus.Umbral_D}, {4'd2, 4'd2, 4'd2});
    init = 1'b0;
    tick();
    chk("reinit_idle", state, 3'd2);
    tick();
    chk("reinit_active2", state, 3'd3);
    check_all("reinit");

    // Priority: error + init in IDLE
    bus.fifo_empty = 5'h1f;
    tick();
    chk("prio_idle", state, 3'd2);
    bus.fifo_error = 5'b00001; init = 1'b1;
    tick();
    bus.fifo_error = '0; init = 1'b0; #1;
    chk("prio_error", state, 3'd4);
    check_all("prio");
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 29) == 0);
      init   = ($urandom_range(0, 7) == 0);
      umf_in = 4'($urandom_range(0, 15));
      uvc_in = 4'($urandom_range(0, 15));
      ud_in  = 4'($urandom_range(0, 15));
      bus.mf_count  = 5'($urandom_range(0, MF_DEPTH));
      bus.vc0_count = 5'($urandom_range(0, VC_DEPTH));
      bus.vc1_count = 5'($urandom_range(0, VC_DEPTH));
      bus.d0_count  = 5'($urandom_range(0, D_DEPTH));
      bus.d1_count  = 5'($urandom_range(0, D_DEPTH));
      bus.fifo_empty = ($urandom_range(0, 1) == 0) ? 5'h1f : 5'($urandom_range(0, 31));
      bus.fifo_error = ($urandom_range(0, 24) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      #1;
      check_all($sformatf("rnd%0d", i));
      tick();
    end
    check_all("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
